// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential remultiplier (dividend reconstruction
// R_0 = Q*D + R_n1 from the outputs of a restoring/non-restoring divider).
//   QW : quotient width           DW : divisor width
//   RW : remainder width          PW : product/result width
//   NW : dividend width; results at or above 2**NW are flagged as overflow
//   state_t : control FSM state encoding
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int QW = 4;
    localparam int DW = 3;
    localparam int RW = 4;
    localparam int PW = 7;
    localparam int NW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/remult_add.sv
// ----------------------------------------------------------------------------
// remult_add
// Combinational shifted-addend adder for one multiply step:
//   o_acc = i_acc + (i_bit ? (i_dreg << i_shift) : 0), all PW bits wide.
// Ports:
//   i_acc   [PW-1:0] running accumulator
//   i_dreg  [DW-1:0] divisor
//   i_bit            quotient bit selecting whether the divisor is added
//   i_shift [SW-1:0] weight of that quotient bit
//   o_acc   [PW-1:0] next accumulator value
// ----------------------------------------------------------------------------
module remult_add #(
    parameter int PW = 7,
    parameter int DW = 3,
    parameter int SW = 2
) (
    input  logic [PW-1:0] i_acc,
    input  logic [DW-1:0] i_dreg,
    input  logic          i_bit,
    input  logic [SW-1:0] i_shift,
    output logic [PW-1:0] o_acc
);

    logic [PW-1:0] w_addend;

    // Select the weighted divisor or zero for this step.
    always_comb begin
        w_addend = {PW{1'b0}};
        if (i_bit) begin
            w_addend = PW'(i_dreg) << i_shift;
        end else begin
            w_addend = {PW{1'b0}};
        end
    end

    assign o_acc = i_acc + w_addend;

endmodule

// File: rtl/seq_remultiplier.sv
// ----------------------------------------------------------------------------
// seq_remultiplier
// Rebuilds the dividend R_0 = Q*D + R_n1 with one shift-and-add step per
// quotient bit, MSB first. Accept on edge k -> out_valid after edge k+QW.
// Result is held in DONE until out_ready; the next operand set can be taken
// only once the block is back in IDLE.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake (in_ready high only in IDLE)
//   Q [QW-1:0]          quotient, Q[QW-1] is the most significant bit
//   D [DW-1:0]          divisor
//   R_n1 [RW-1:0]       remainder
//   out_valid/out_ready result handshake
//   R_0 [PW-1:0]        reconstructed dividend
//   ovf                 result >= 2**NW
// Configuration:
//   REMULT_OVF_CHECK_EN defined   : ovf is the registered (acc >= 2**NW) flag
//   REMULT_OVF_CHECK_EN undefined : ovf tied low, no compare logic
// ----------------------------------------------------------------------------
module seq_remultiplier #(
    parameter int QW = div_pkg::QW,
    parameter int DW = div_pkg::DW,
    parameter int RW = div_pkg::RW,
    parameter int PW = div_pkg::PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] Q,
    input  logic [DW-1:0] D,
    input  logic [RW-1:0] R_n1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] R_0,
    output logic          ovf
);

    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    div_pkg::state_t r_state;
    logic [PW-1:0]   r_acc;
    logic [QW-1:0]   r_qreg;
    logic [DW-1:0]   r_dreg;
    logic [CW-1:0]   r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [PW-1:0]   r_R_0;
    logic [PW-1:0]   w_acc_next;
    logic            w_qbit;
    logic            w_last_step;

    assign w_qbit      = r_qreg[r_cnt];
    assign w_last_step = (r_state == div_pkg::RUN) && (r_cnt == {CW{1'b0}});

    remult_add #(
        .PW (PW),
        .DW (DW),
        .SW (CW)
    ) u_add (
        .i_acc   (r_acc),
        .i_dreg  (r_dreg),
        .i_bit   (w_qbit),
        .i_shift (r_cnt),
        .o_acc   (w_acc_next)
    );

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= div_pkg::IDLE;
            r_acc       <= {PW{1'b0}};
            r_qreg      <= {QW{1'b0}};
            r_dreg      <= {DW{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_R_0       <= {PW{1'b0}};
        end else begin
            case (r_state)
                div_pkg::IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_acc      <= PW'(R_n1);
                        r_qreg     <= Q;
                        r_dreg     <= D;
                        r_cnt      <= CW'(QW - 1);
                        r_in_ready <= 1'b0;
                        r_state    <= div_pkg::RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                div_pkg::RUN: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == {CW{1'b0}}) begin
                        // Final step: publish the sum produced this cycle.
                        r_R_0       <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= div_pkg::DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                div_pkg::DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= div_pkg::IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= div_pkg::IDLE;
                end
            endcase
        end
    end

`ifdef REMULT_OVF_CHECK_EN
    localparam logic [PW-1:0] OVF_LIM = PW'(1 << div_pkg::NW);

    logic r_ovf;

    // Overflow flag captured together with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last_step) begin
            r_ovf <= (w_acc_next >= OVF_LIM);
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign R_0       = r_R_0;

endmodule

// File: tb/tb_seq_remultiplier.sv
// ----------------------------------------------------------------------------
// tb_seq_remultiplier
// Directed plus back-to-back random checks of seq_remultiplier. Expected
// results come from Q*D + R_n1 computed here and are queued at accept time.
// Honours REMULT_OVF_CHECK_EN when building the expected ovf.
// ----------------------------------------------------------------------------
module tb_seq_remultiplier;

    localparam int QW = 4;
    localparam int DW = 3;
    localparam int RW = 4;
    localparam int PW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [QW-1:0] Q;
    logic [DW-1:0] D;
    logic [RW-1:0] R_n1;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] R_0;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    // Each entry is {expected ovf, expected R_0}.
    logic [PW:0] exp_q[$];

    always #5 clk = ~clk;

    seq_remultiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Q         (Q),
        .D         (D),
        .R_n1      (R_n1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R_0       (R_0),
        .ovf       (ovf)
    );

    function automatic logic [PW:0] model(input int q, input int d, input int r);
        int           v;
        logic         o;
        logic [PW-1:0] vv;
        v  = q * d + r;
        vv = v[PW-1:0];
        o  = 1'b0;
`ifdef REMULT_OVF_CHECK_EN
        o = (v >= 64);
`endif
        return {o, vv};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        logic [PW:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=result expected=empty_queue", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_r0"}, 32'(R_0), 32'(e[PW-1:0]));
            check({tag, "_ovf"}, 32'(ovf), 32'(e[PW]));
        end
    endtask

    // One directed operation; hold>0 keeps out_ready low that many cycles.
    task automatic run_op(input string tag, input int q, input int d, input int r, input int hold);
        logic [PW-1:0] held;
        check({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        Q = QW'(q); D = DW'(d); R_n1 = RW'(r);
        in_valid = 1'b1;
        exp_q.push_back(model(q, d, r));
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Operands changing after accept must not matter.
        Q = ~Q; D = ~D; R_n1 = ~R_n1;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        for (int i = 1; i <= QW; i++) begin
            @(posedge clk); #1;
            check({tag, "_lat"}, 32'(out_valid), (i == QW) ? 32'd1 : 32'd0);
        end
        check_result(tag);
        held = R_0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_r0"}, 32'(R_0), 32'(held));
            check({tag, "_hold_busy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int got;
        int last;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Q = '0; D = '0; R_n1 = '0;
        #12;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_r0", 32'(R_0), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("q5d3r2", 5, 3, 2, 0);
        run_op("max", 15, 7, 15, 0);
        run_op("d0", 9, 0, 6, 0);
        run_op("q0", 0, 5, 4, 0);
        run_op("hold", 11, 6, 9, 10);

        // Reset in the second RUN cycle abandons the operation.
        Q = 4'd7; D = 3'd7; R_n1 = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_op("after_rst", 3, 4, 1, 0);

        // Back-to-back random sets with in_valid held high.
        got = 0; last = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 1400 && got < 200; cyc++) begin
            Q = QW'($urandom); D = DW'($urandom); R_n1 = RW'($urandom);
            if (in_ready) exp_q.push_back(model(int'(Q), int'(D), int'(R_n1)));
            if (out_valid) begin
                check_result("b2b");
                if (last >= 0) check("b2b_period", 32'(cyc - last), 32'd6);
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("b2b_count", 32'(got), 32'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
